// File: rtl/stream_demux_if.sv
// ----------------------------------------------------------------------------
// stream_demux_if
//   Bundles the producer-side valid/ready stream and the N consumer-side
//   valid/ready streams of stream_demux.
//   master : the environment (drives in_* and out_ready)
//   slave  : the demux itself (drives in_ready, out_valid, out_data)
//   Signals:
//     in_valid / in_ready / in_data[W] / in_sel[SELW] / in_bcast : input beat
//     out_valid[N] / out_ready[N] / out_data[N*W]                : channels,
//       channel i occupies out_data[i*W +: W]
// ----------------------------------------------------------------------------
interface stream_demux_if #(
   parameter int N    = 8,
   parameter int W    = 8,
   parameter int SELW = $clog2(N)
);
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   logic [SELW-1:0] in_sel;
   logic            in_bcast;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready;
   logic [N*W-1:0]  out_data;

   modport master (
      output in_valid, in_data, in_sel, in_bcast, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_sel, in_bcast, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux
//   Registered 1-to-N valid/ready demultiplexer. Each accepted beat goes to
//   channel in_sel, or to all channels when in_bcast=1. Every channel owns a
//   one-deep output register, so a stalled channel only blocks beats aimed
//   at it (or broadcasts). Beats with in_sel >= N are accepted, discarded
//   and counted in a saturating 16-bit drop counter.
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous reset, active-high
//     s          : stream_demux_if.slave (input stream + N output streams)
//     drop_count : beats discarded for out-of-range in_sel (saturating)
// ----------------------------------------------------------------------------
module stream_demux #(
   parameter int N    = 8,
   parameter int W    = 8,
   parameter int SELW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   stream_demux_if.slave s,
   output logic [15:0]   drop_count
);

   localparam logic [SELW:0] NCH = (SELW+1)'(N);

   logic [N-1:0]   out_valid_r;
   logic [N*W-1:0] out_data_r;
   logic [15:0]    drop_count_r;

   logic [N-1:0]   free_s;
   logic [N-1:0]   load_s;
   logic           sel_ok_s;
   logic           in_ready_s;
   logic           accept_s;
   logic           drop_s;

   // A channel can take a new word if empty or draining this cycle.
   always_comb begin
      free_s = ~out_valid_r | s.out_ready;
   end

   // in_sel names a real channel (always true when N is a power of two).
   always_comb begin
      sel_ok_s = ({1'b0, s.in_sel} < NCH);
   end

   // Input-side ready; out-of-range unicast beats are always swallowed.
   always_comb begin
      if (rst) begin
         in_ready_s = 1'b0;
      end else if (s.in_bcast) begin
         in_ready_s = &free_s;
      end else if (sel_ok_s) begin
         in_ready_s = free_s[s.in_sel];
      end else begin
         in_ready_s = 1'b1;
      end
   end

   // Accept, drop and per-channel load decode.
   always_comb begin
      accept_s = s.in_valid && in_ready_s;
      drop_s   = accept_s && !s.in_bcast && !sel_ok_s;
      load_s   = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (accept_s && s.in_bcast) begin
            load_s[i] = 1'b1;
         end else if (accept_s && sel_ok_s && (s.in_sel == SELW'(i))) begin
            load_s[i] = 1'b1;
         end else begin
            load_s[i] = 1'b0;
         end
      end
   end

   // Channel registers: load wins over drain, so back-to-back beats leave no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= {N{1'b0}};
         out_data_r  <= {(N*W){1'b0}};
      end else begin
         for (int i = 0; i < N; i++) begin
            if (load_s[i]) begin
               out_valid_r[i]          <= 1'b1;
               out_data_r[i*W +: W]    <= s.in_data;
            end else if (s.out_ready[i]) begin
               out_valid_r[i]          <= 1'b0;
            end else begin
               out_valid_r[i]          <= out_valid_r[i];
            end
         end
      end
   end

   // Saturating counter of discarded out-of-range beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count_r <= 16'h0000;
      end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
         drop_count_r <= drop_count_r + 16'd1;
      end else begin
         drop_count_r <= drop_count_r;
      end
   end

   assign s.in_ready  = in_ready_s;
   assign s.out_valid = out_valid_r;
   assign s.out_data  = out_data_r;
   assign drop_count  = drop_count_r;

endmodule
